pipe_stage_skid: RTL

- Parametrised pipeline-stage register. Successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload and a control payload between two pipeline stages using a valid/ready handshake.
- Supports synchronous flush, which clears only the control fields, in the same way write-enable bits are clearedd on a stage clear.
- Optional 2-entry skid buffer breaks the combinational ready path. A saturating stall counter is provided for performance monitoring.

---
 rtl/pipe_stage_skid.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic pipeline-stage register. It moves a data payload and a control
// payload between two stages with a valid/ready handshake. It replaces the
// fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//
// With SKID_EN=1 the stage holds up to two beats: a main register and a skid
// register. in_ready then comes straight from a flop. With SKID_EN=0 the stage
// is a single register, and in_ready passes out_ready through combinationally.
//
// A flush clears the valid bits and returns the control fields to CTRL_RST.
// The data fields are left untouched, just as a stage clear only drops the
// write-enable style bits. A saturating counter records the cycles in which
// the head beat is held back by the downstream stage.
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous stage clear; ranks just below reset
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can take a beat this cycle
//   in_data    in   upstream data payload  [DATA_W]
//   in_ctrl    in   upstream control payload [CTRL_W]
//   out_valid  out  head beat valid
//   out_ready  in   downstream takes the head beat
//   out_data   out  head data payload      [DATA_W]
//   out_ctrl   out  head control payload   [CTRL_W]
//   stall_cnt  out  saturating count of out_valid & ~out_ready cycles [CNT_W]
//   cnt_clr    in   synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int                SKID_EN  = 1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    // The encoding is {out_valid, skid_valid}. Bit 1 is the head-valid flag.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL1 = 2'b10,
        ST_FULL2 = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    // Skid register contents as seen by the main-register logic.
    logic [DATA_W-1:0]   skid_data;
    logic [CTRL_W-1:0]   skid_ctrl;

    logic                acc;
    logic                pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;

    // -------------------------------------------------------------------------
    // Main register and occupancy state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    state_d     = ST_FULL1;
                end
            end
            ST_FULL1: begin
                if (pop && acc) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end else if (acc) begin
                    // Without a skid register, acc here already implies pop,
                    // so this branch is only reachable when SKID_EN=1.
                    if (SKID_EN != 0) begin
                        state_d = ST_FULL2;
                    end
                end
            end
            ST_FULL2: begin
                // in_ready is low here, so only the skid-to-main move happens.
                if (pop) begin
                    main_data_d = skid_data;
                    main_ctrl_d = skid_ctrl;
                    state_d     = ST_FULL1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // A flush drops every beat, including one accepted in this cycle.
        // The data field keeps its old contents.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = CTRL_RST;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_RST;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional skid register
    // -------------------------------------------------------------------------
    generate
        if (SKID_EN != 0) begin : g_skid
            logic [DATA_W-1:0] skid_data_q, skid_data_d;
            logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
            logic              skid_valid;
            logic              skid_load;

            assign skid_valid = (state_q == ST_FULL2);
            // in_ready comes only from the state flop, so out_ready never
            // reaches it combinationally.
            assign in_ready   = ~skid_valid;
            // The skid register catches a beat that arrives while the head is
            // stuck.
            assign skid_load  = (state_q == ST_FULL1) & acc & ~pop;

            always_comb begin
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                if (skid_load) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end
                if (flush) begin
                    skid_data_d = skid_data_q;
                    skid_ctrl_d = CTRL_RST;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= CTRL_RST;
                end else begin
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                end
            end

            assign skid_data = skid_data_q;
            assign skid_ctrl = skid_ctrl_q;
        end else begin : g_noskid
            // A single register can take a new beat whenever its current
            // beat leaves in the same cycle.
            assign in_ready  = ~out_valid | out_ready;
            assign skid_data = '0;
            assign skid_ctrl = CTRL_RST;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stall counter
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
